// File: rtl/pipeline_hazard_tracker_if.sv
// pipeline_hazard_tracker_if
//   Groups the hazard tracker's ID-stage issue/read signals, the execute and
//   memory result buses, and the forwarding/stall/writeback outputs.
//   Ports (via modports):
//     slave  : the tracker itself. It receives the issue, result and read
//              signals and drives rs_data, fwd_hit, want_stall and wb_*.
//     master : the pipeline side. It drives the issue, result and read
//              signals and receives the tracker outputs.
interface pipeline_hazard_tracker_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_READ = 2
);
    logic                     issue_valid;
    logic [4:0]               issue_rd;
    logic                     issue_early;
    logic [XLEN-1:0]          ex_data;
    logic [XLEN-1:0]          late_data;
    logic [NUM_READ*5-1:0]    rs_addr;
    logic [NUM_READ-1:0]      rs_used;
    logic [NUM_READ*XLEN-1:0] rf_data;
    logic [NUM_READ*XLEN-1:0] rs_data;
    logic [NUM_READ-1:0]      fwd_hit;
    logic                     want_stall;
    logic                     wb_valid;
    logic [4:0]               wb_rd;
    logic [XLEN-1:0]          wb_data;

    modport master (
        output issue_valid, issue_rd, issue_early, ex_data, late_data,
               rs_addr, rs_used, rf_data,
        input  rs_data, fwd_hit, want_stall, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  issue_valid, issue_rd, issue_early, ex_data, late_data,
               rs_addr, rs_used, rf_data,
        output rs_data, fwd_hit, want_stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/pipeline_hazard_tracker.sv
// pipeline_hazard_tracker
//   Tracks in-flight register writes across DEPTH post-ID stages. It forwards
//   the youngest matching result to the NUM_READ ID-stage source ports, and it
//   requests a stall when the youngest match has no result yet. The last stage
//   drives the regfile write port.
//   Ports:
//     clock, reset : rising-edge clock; synchronous active-high reset
//     bus (slave)  : issue_*, ex_data, late_data, rs_addr, rs_used, rf_data in;
//                    rs_data, fwd_hit, want_stall, wb_valid, wb_rd, wb_data out
//   Optional feature macro FORWARD_STATS_EN adds the stall_count and
//   fwd_count outputs. Both are 32-bit event counters that wrap.
module pipeline_hazard_tracker #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned LATE_STAGE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    pipeline_hazard_tracker_if.slave bus
`ifdef FORWARD_STATS_EN
    ,
    output logic [31:0]              stall_count,
    output logic [31:0]              fwd_count
`endif
);

    logic            valid_q [DEPTH];
    logic            valid_d [DEPTH];
    logic [4:0]      rd_q    [DEPTH];
    logic [4:0]      rd_d    [DEPTH];
    logic            early_q [DEPTH];
    logic            early_d [DEPTH];
    logic [XLEN-1:0] data_q  [DEPTH];
    logic [XLEN-1:0] data_d  [DEPTH];

    logic            stage_avail [DEPTH];
    logic [XLEN-1:0] stage_val   [DEPTH];

    logic                     want_stall_c;
    logic [NUM_READ*XLEN-1:0] rs_data_c;
    logic [NUM_READ-1:0]      fwd_hit_c;
    logic [4:0]               addr_c;
    logic                     match_c;
    logic                     match_avail_c;
    logic [XLEN-1:0]          match_val_c;

    // Each stage's current value. A stage's result is either live on a
    // result bus this cycle or already registered.
    always_comb begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
            stage_avail[s] = 1'b0;
            stage_val[s]   = data_q[s];
            if (s == 0 && early_q[s]) begin
                stage_avail[s] = 1'b1;
                stage_val[s]   = bus.ex_data;
            end else if (s == LATE_STAGE && !early_q[s]) begin
                stage_avail[s] = 1'b1;
                stage_val[s]   = bus.late_data;
            end else if (s > LATE_STAGE || (s > 0 && early_q[s])) begin
                stage_avail[s] = 1'b1;
            end
        end
    end

    // The search runs from oldest to youngest, so the youngest match wins.
    // A match without a result blocks any older value and raises a stall.
    always_comb begin
        want_stall_c  = 1'b0;
        rs_data_c     = bus.rf_data;
        fwd_hit_c     = '0;
        addr_c        = '0;
        match_c       = 1'b0;
        match_avail_c = 1'b0;
        match_val_c   = '0;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            addr_c        = bus.rs_addr[p*5 +: 5];
            match_c       = 1'b0;
            match_avail_c = 1'b0;
            match_val_c   = '0;
            for (int unsigned s = DEPTH; s > 0; s--) begin
                if (valid_q[s-1] && rd_q[s-1] == addr_c) begin
                    match_c       = 1'b1;
                    match_avail_c = stage_avail[s-1];
                    match_val_c   = stage_val[s-1];
                end
            end
            if (match_c && match_avail_c) begin
                rs_data_c[p*XLEN +: XLEN] = match_val_c;
                fwd_hit_c[p]              = 1'b1;
            end else if (match_c && bus.rs_used[p]) begin
                want_stall_c = 1'b1;
            end
        end
    end

    // Shift the pipeline by one stage. A stalled issue becomes a bubble.
    // Results are captured as their entries leave the producing stage.
    always_comb begin
        valid_d[0] = bus.issue_valid && !want_stall_c && (bus.issue_rd != 5'd0);
        rd_d[0]    = valid_d[0] ? bus.issue_rd : 5'd0;
        early_d[0] = valid_d[0] && bus.issue_early;
        data_d[0]  = '0;
        for (int unsigned s = 1; s < DEPTH; s++) begin
            valid_d[s] = valid_q[s-1];
            rd_d[s]    = rd_q[s-1];
            early_d[s] = early_q[s-1];
            data_d[s]  = data_q[s-1];
            if (valid_q[s-1]) begin
                if (s == 1 && early_q[s-1]) begin
                    data_d[s] = bus.ex_data;
                end else if (s - 1 == LATE_STAGE && !early_q[s-1]) begin
                    data_d[s] = bus.late_data;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                valid_q[s] <= 1'b0;
                rd_q[s]    <= 5'd0;
                early_q[s] <= 1'b0;
                data_q[s]  <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                valid_q[s] <= valid_d[s];
                rd_q[s]    <= rd_d[s];
                early_q[s] <= early_d[s];
                data_q[s]  <= data_d[s];
            end
        end
    end

    assign bus.rs_data    = rs_data_c;
    assign bus.fwd_hit    = fwd_hit_c;
    assign bus.want_stall = want_stall_c;
    assign bus.wb_valid   = valid_q[DEPTH-1];
    assign bus.wb_rd      = rd_q[DEPTH-1];
    assign bus.wb_data    = data_q[DEPTH-1];

`ifdef FORWARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] fwd_count_q,   fwd_count_d;

    always_comb begin
        stall_count_d = stall_count_q + {31'd0, want_stall_c};
        fwd_count_d   = fwd_count_q;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            if (fwd_hit_c[p] && bus.rs_used[p]) begin
                fwd_count_d = fwd_count_d + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_q <= '0;
            fwd_count_q   <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            fwd_count_q   <= fwd_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign fwd_count   = fwd_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_tracker.sv
// tb_pipeline_hazard_tracker
//   Drives two trackers with identical stimulus: the default configuration
//   (DEPTH=3, LATE_STAGE=1) and a deeper one (DEPTH=4, LATE_STAGE=2).
//   The reference model keeps a per-cycle history of accepted instructions
//   and result-bus values, and it derives each instruction's stage from its
//   age in cycles.
module tb_pipeline_hazard_tracker;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NR   = 2;
    localparam int          NCYC = 1200;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pipeline_hazard_tracker_if #(.XLEN(XLEN), .NUM_READ(NR)) bus0 ();
    pipeline_hazard_tracker_if #(.XLEN(XLEN), .NUM_READ(NR)) bus1 ();

`ifdef FORWARD_STATS_EN
    logic [31:0] sc0, fc0, sc1, fc1;
`endif

    pipeline_hazard_tracker #(.XLEN(XLEN), .DEPTH(3), .NUM_READ(NR), .LATE_STAGE(1)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
`ifdef FORWARD_STATS_EN
        , .stall_count(sc0), .fwd_count(fc0)
`endif
    );

    pipeline_hazard_tracker #(.XLEN(XLEN), .DEPTH(4), .NUM_READ(NR), .LATE_STAGE(2)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1)
`ifdef FORWARD_STATS_EN
        , .stall_count(sc1), .fwd_count(fc1)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int T        = 0;
    int flush_c  = 0;

    bit          acc     [2][NCYC];
    logic [4:0]  a_rd    [2][NCYC];
    bit          a_early [2][NCYC];
    logic [31:0] ex_h    [NCYC];
    logic [31:0] late_h  [NCYC];
    logic [31:0] rf_cur  [NR];

    logic          o_stall [2];
    logic          o_wbv   [2];
    logic [4:0]    o_wbrd  [2];
    logic [31:0]   o_wbd   [2];
    logic [NR-1:0] o_hit   [2];
    logic [31:0]   o_rs    [2][NR];
    logic [31:0]   o_sc    [2];
    logic [31:0]   o_fc    [2];
    logic [31:0]   m_sc    [2];
    logic [31:0]   m_fc    [2];

    function automatic int dp(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    function automatic int ls(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, obs, exp, T);
        end
    endtask

    // Finds the youngest in-flight writer of rs. An instruction accepted in
    // cycle c sits in stage T-1-c. Its result appears on ex_data one cycle
    // after acceptance (early) or LATE_STAGE cycles after that (late).
    task automatic lookup(input int k, input logic [4:0] rs,
                          output bit found, output bit avail, output logic [31:0] val);
        found = 0;
        avail = 0;
        val   = '0;
        for (int age = 0; age < dp(k); age++) begin
            int c = T - 1 - age;
            if (!found && c >= flush_c && c >= 0 && acc[k][c] && a_rd[k][c] == rs) begin
                int rc = a_early[k][c] ? c + 1 : c + 1 + ls(k);
                found = 1;
                avail = (rc <= T);
                if (avail) val = a_early[k][c] ? ex_h[rc] : late_h[rc];
            end
        end
    endtask

    task automatic step(input bit rst, input bit iv, input logic [4:0] rd, input bit early,
                        input logic [31:0] ex, input logic [31:0] late,
                        input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used);
        logic [4:0] addr [NR];
        reset = rst;
        rf_cur[0] = $urandom;
        rf_cur[1] = $urandom;
        addr[0] = a0;
        addr[1] = a1;
        bus0.issue_valid = iv;  bus1.issue_valid = iv;
        bus0.issue_rd    = rd;  bus1.issue_rd    = rd;
        bus0.issue_early = early; bus1.issue_early = early;
        bus0.ex_data     = ex;  bus1.ex_data     = ex;
        bus0.late_data   = late; bus1.late_data  = late;
        bus0.rs_addr     = {a1, a0}; bus1.rs_addr = {a1, a0};
        bus0.rs_used     = used; bus1.rs_used    = used;
        bus0.rf_data     = {rf_cur[1], rf_cur[0]};
        bus1.rf_data     = {rf_cur[1], rf_cur[0]};
        ex_h[T]   = ex;
        late_h[T] = late;
        #1;
        o_stall[0] = bus0.want_stall; o_stall[1] = bus1.want_stall;
        o_wbv[0]   = bus0.wb_valid;   o_wbv[1]   = bus1.wb_valid;
        o_wbrd[0]  = bus0.wb_rd;      o_wbrd[1]  = bus1.wb_rd;
        o_wbd[0]   = bus0.wb_data;    o_wbd[1]   = bus1.wb_data;
        o_hit[0]   = bus0.fwd_hit;    o_hit[1]   = bus1.fwd_hit;
        for (int p = 0; p < NR; p++) begin
            o_rs[0][p] = bus0.rs_data[p*XLEN +: XLEN];
            o_rs[1][p] = bus1.rs_data[p*XLEN +: XLEN];
        end
`ifdef FORWARD_STATS_EN
        o_sc[0] = sc0; o_fc[0] = fc0; o_sc[1] = sc1; o_fc[1] = fc1;
`endif
        for (int k = 0; k < 2; k++) begin
            bit st = 0;
            int nfwd = 0;
            int c;
            for (int p = 0; p < NR; p++) begin
                bit found, avail;
                logic [31:0] val;
                lookup(k, addr[p], found, avail, val);
                if (used[p] && found && !avail) st = 1;
                if (used[p] && found && avail) nfwd++;
                check($sformatf("d%0d.hit%0d", k, p), {31'd0, o_hit[k][p]}, {31'd0, found && avail});
                if (!found) check($sformatf("d%0d.rf%0d", k, p), o_rs[k][p], rf_cur[p]);
                else if (avail) check($sformatf("d%0d.fwd%0d", k, p), o_rs[k][p], val);
            end
            check($sformatf("d%0d.stall", k), {31'd0, o_stall[k]}, {31'd0, st});
            c = T - dp(k);
            if (c >= flush_c && c >= 0 && acc[k][c]) begin
                int rc = a_early[k][c] ? c + 1 : c + 1 + ls(k);
                check($sformatf("d%0d.wbv", k), {31'd0, o_wbv[k]}, 32'd1);
                check($sformatf("d%0d.wbrd", k), {27'd0, o_wbrd[k]}, {27'd0, a_rd[k][c]});
                check($sformatf("d%0d.wbd", k), o_wbd[k], a_early[k][c] ? ex_h[rc] : late_h[rc]);
            end else begin
                check($sformatf("d%0d.wbv", k), {31'd0, o_wbv[k]}, 32'd0);
            end
`ifdef FORWARD_STATS_EN
            check($sformatf("d%0d.stall_count", k), o_sc[k], m_sc[k]);
            check($sformatf("d%0d.fwd_count", k), o_fc[k], m_fc[k]);
            if (rst) begin
                m_sc[k] = '0;
                m_fc[k] = '0;
            end else begin
                m_sc[k] = m_sc[k] + (st ? 32'd1 : 32'd0);
                m_fc[k] = m_fc[k] + 32'(nfwd);
            end
`endif
            acc[k][T]     = iv && !st && (rd != 5'd0);
            a_rd[k][T]    = rd;
            a_early[k][T] = early;
        end
        if (rst) flush_c = T + 1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        T++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 5'd0, 0, $urandom, $urandom, 5'd0, 5'd0, 2'b00);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_sc[0] = '0; m_sc[1] = '0; m_fc[0] = '0; m_fc[1] = '0;
        bus0.issue_valid = 0; bus1.issue_valid = 0;
        bus0.issue_rd = '0; bus1.issue_rd = '0;
        bus0.issue_early = 0; bus1.issue_early = 0;
        bus0.ex_data = '0; bus1.ex_data = '0;
        bus0.late_data = '0; bus1.late_data = '0;
        bus0.rs_addr = '0; bus1.rs_addr = '0;
        bus0.rs_used = '0; bus1.rs_used = '0;
        bus0.rf_data = '0; bus1.rf_data = '0;
        reset = 1;
        repeat (2) @(posedge clock);
        #1;
        T = 0;
        flush_c = 0;

        // Reset state: the pipeline is empty, so all reads come from the regfile.
        step(0, 0, 5'd0, 0, 32'h0, 32'h0, 5'd5, 5'd6, 2'b11);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst.d%0d.wbv", k), {31'd0, o_wbv[k]}, 32'd0);
            check($sformatf("rst.d%0d.wbrd", k), {27'd0, o_wbrd[k]}, 32'd0);
            check($sformatf("rst.d%0d.wbd", k), o_wbd[k], 32'd0);
            check($sformatf("rst.d%0d.stall", k), {31'd0, o_stall[k]}, 32'd0);
            check($sformatf("rst.d%0d.hit", k), {30'd0, o_hit[k]}, 32'd0);
`ifdef FORWARD_STATS_EN
            check($sformatf("rst.d%0d.sc", k), o_sc[k], 32'd0);
            check($sformatf("rst.d%0d.fc", k), o_fc[k], 32'd0);
`endif
        end
        tick();

        // ALU result forwarded to the very next instruction.
        step(0, 1, 5'd5, 1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'h11, 32'h0, 5'd5, 5'd0, 2'b01);
        check("alu.d0.rs", o_rs[0][0], 32'h11);
        check("alu.d0.hit", {31'd0, o_hit[0][0]}, 32'd1);
        check("alu.d1.stall", {31'd0, o_stall[1]}, 32'd0);
        tick(); idle(5);

        // Load-use: stall LATE_STAGE cycles; an issue during the stall is dropped.
        step(0, 1, 5'd7, 0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 1, 5'd12, 1, 32'h0, 32'h0, 5'd7, 5'd0, 2'b01);
        check("ld.d0.stall1", {31'd0, o_stall[0]}, 32'd1);
        check("ld.d1.stall1", {31'd0, o_stall[1]}, 32'd1);
        tick();
        step(0, 0, 5'd0, 0, 32'h0, 32'hABCD, 5'd7, 5'd12, 2'b01);
        check("ld.d0.stall2", {31'd0, o_stall[0]}, 32'd0);
        check("ld.d0.rs", o_rs[0][0], 32'hABCD);
        check("ld.d0.bubble", {31'd0, o_hit[0][1]}, 32'd0);
        check("ld.d1.stall2", {31'd0, o_stall[1]}, 32'd1);
        tick();
        step(0, 0, 5'd0, 0, 32'h0, 32'h1234, 5'd7, 5'd0, 2'b01);
        check("ld.d0.rs_reg", o_rs[0][0], 32'hABCD);
        check("ld.d0.wbv", {31'd0, o_wbv[0]}, 32'd1);
        check("ld.d0.wbrd", {27'd0, o_wbrd[0]}, 32'd7);
        check("ld.d0.wbd", o_wbd[0], 32'hABCD);
        check("ld.d1.stall3", {31'd0, o_stall[1]}, 32'd0);
        check("ld.d1.rs", o_rs[1][0], 32'h1234);
        tick();
        step(0, 0, 5'd0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00);
        check("ld.d1.wbv", {31'd0, o_wbv[1]}, 32'd1);
        check("ld.d1.wbrd", {27'd0, o_wbrd[1]}, 32'd7);
        check("ld.d1.wbd", o_wbd[1], 32'h1234);
        tick(); idle(5);

        // Shadowing: the younger writer of x3 wins over the older one.
        step(0, 1, 5'd3, 1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'hAA, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 1, 5'd3, 1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'hBB, 32'h0, 5'd3, 5'd0, 2'b01);
        check("shadow.d0.rs", o_rs[0][0], 32'hBB);
        tick(); idle(5);
        step(0, 1, 5'd3, 1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'hAA, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 1, 5'd3, 0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'hBB, 32'h0, 5'd3, 5'd0, 2'b01);
        check("shadow_ld.d0.stall", {31'd0, o_stall[0]}, 32'd1);
        check("shadow_ld.d0.hit", {31'd0, o_hit[0][0]}, 32'd0);
        tick(); idle(5);

        // x0 is never tracked; an unused operand never stalls.
        step(0, 1, 5'd0, 1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'h55, 32'h0, 5'd0, 5'd0, 2'b01);
        check("x0.d0.hit", {31'd0, o_hit[0][0]}, 32'd0);
        check("x0.d0.rs", o_rs[0][0], rf_cur[0]);
        tick();
        step(0, 1, 5'd9, 0, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'h0, 32'h0, 5'd9, 5'd0, 2'b00);
        check("unused.d0.stall", {31'd0, o_stall[0]}, 32'd0);
        check("unused.d1.stall", {31'd0, o_stall[1]}, 32'd0);
        tick(); idle(5);

        // Reset with three valid entries in flight: nothing is written back.
        step(0, 1, 5'd1, 1, 32'h0, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 1, 5'd2, 1, 32'h21, 32'h0, 5'd0, 5'd0, 2'b00); tick();
        step(0, 1, 5'd3, 1, 32'h22, 32'h0, 5'd1, 5'd0, 2'b01); tick();
        step(1, 0, 5'd0, 0, 32'h23, 32'h0, 5'd2, 5'd0, 2'b00); tick();
        step(0, 0, 5'd0, 0, 32'h0, 32'h0, 5'd1, 5'd2, 2'b11);
        check("midrst.d0.wbv", {31'd0, o_wbv[0]}, 32'd0);
        check("midrst.d1.wbv", {31'd0, o_wbv[1]}, 32'd0);
`ifdef FORWARD_STATS_EN
        check("midrst.d0.sc", o_sc[0], 32'd0);
        check("midrst.d0.fc", o_fc[0], 32'd0);
`endif
        tick(); idle(4);

        // Randomized traffic over a small register range to force frequent hits.
        for (int i = 0; i < 800; i++) begin
            bit rst = ($urandom_range(0, 96) == 0);
            step(rst, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom, $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
